// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: valid/ready configuration channel for led_pattern_gen.
// The master offers mode/period/duty with cfg_valid. The slave accepts the
// offer when cfg_ready is high.
interface led_pattern_gen_if #(
  parameter int PERIOD_W = 16
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [1:0]          cfg_mode;
  logic [PERIOD_W-1:0] cfg_period;
  logic [PERIOD_W-1:0] cfg_duty;

  modport master (
    output cfg_valid,
    output cfg_mode,
    output cfg_period,
    output cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_mode,
    input  cfg_period,
    input  cfg_duty,
    output cfg_ready
  );
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-pattern LED driver running from one prescaled tick.
// Supported patterns are OFF, BLINK, CHASE and ALT. They are built from a
// phase counter and a chase position.
// A new configuration is held in a pending register. It is applied on a
// period wrap, or on the next cycle when the block is OFF, so the LED
// outputs never glitch.
// Build option: define LED_INVERT_EN for active-low LED pins. With it
// defined, the reset value is all ones and OFF drives all ones.
module led_pattern_gen #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int NUM_LEDS = 8,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  led_pattern_gen_if.slave    cfg,
  output logic [NUM_LEDS-1:0] leds,
  output logic                tick,
  output logic                cycle_done
);

  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int POS_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  // The prescaler value one cycle before the tick. Registering tick from
  // this value makes tick high exactly while the count is TICK_DIV-1.
  localparam logic [PRESC_W-1:0] PRESC_PRE  = PRESC_W'(TICK_DIV - 2);
  localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(NUM_LEDS - 1);

`ifdef LED_INVERT_EN
  localparam logic [NUM_LEDS-1:0] LED_POLARITY = {NUM_LEDS{1'b1}};
`else
  localparam logic [NUM_LEDS-1:0] LED_POLARITY = {NUM_LEDS{1'b0}};
`endif

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_ALT   = 2'd3
  } mode_t;

  // Active configuration and counters
  logic [PRESC_W-1:0]  presc_r;
  logic [PERIOD_W-1:0] phase_r;
  logic [PERIOD_W-1:0] period_r;
  logic [PERIOD_W-1:0] duty_r;
  mode_t               mode_r;
  logic [POS_W-1:0]    pos_r;

  // Pending configuration; a pending config exists while ready_r is low
  logic                ready_r;
  mode_t               pend_mode_r;
  logic [PERIOD_W-1:0] pend_period_r;
  logic [PERIOD_W-1:0] pend_duty_r;

  // Registered outputs
  logic                tick_r;
  logic                cycle_done_r;
  logic [NUM_LEDS-1:0] leds_r;

  // Combinational next-state values
  logic [PRESC_W-1:0]  presc_next_s;
  logic [PERIOD_W-1:0] phase_next_s;
  logic [PERIOD_W-1:0] period_next_s;
  logic [PERIOD_W-1:0] duty_next_s;
  mode_t               mode_next_s;
  logic [POS_W-1:0]    pos_next_s;
  logic                tick_next_s;
  logic                cycle_done_next_s;
  logic                wrap_s;
  logic                accept_s;
  logic                apply_s;
  logic                on_s;
  logic [NUM_LEDS-1:0] pattern_s;

  // Compute the next time base, the next phase/position and the next active config.
  always_comb begin
    presc_next_s      = presc_r;
    phase_next_s      = phase_r;
    pos_next_s        = pos_r;
    mode_next_s       = mode_r;
    period_next_s     = period_r;
    duty_next_s       = duty_r;
    tick_next_s       = 1'b0;
    cycle_done_next_s = 1'b0;

    wrap_s   = tick_r && (phase_r == (period_r - PERIOD_W'(1)));
    accept_s = cfg.cfg_valid && ready_r;
    // The accept cycle itself never applies, because ready_r is still high
    // in that cycle. An accept on a wrap therefore waits for the next wrap.
    apply_s  = !ready_r && ((mode_r == MODE_OFF) || wrap_s);

    if (presc_r == PRESC_LAST) begin
      presc_next_s = '0;
    end else begin
      presc_next_s = presc_r + PRESC_W'(1);
    end

    if (wrap_s) begin
      phase_next_s = '0;
      if (pos_r == POS_LAST) begin
        pos_next_s = '0;
      end else begin
        pos_next_s = pos_r + POS_W'(1);
      end
    end else if (tick_r) begin
      phase_next_s = phase_r + PERIOD_W'(1);
      pos_next_s   = pos_r;
    end else begin
      phase_next_s = phase_r;
      pos_next_s   = pos_r;
    end

    // Applying a config restarts the pattern but leaves the prescaler alone.
    if (apply_s) begin
      mode_next_s   = pend_mode_r;
      period_next_s = pend_period_r;
      duty_next_s   = pend_duty_r;
      phase_next_s  = '0;
      pos_next_s    = '0;
    end else begin
      mode_next_s   = mode_r;
      period_next_s = period_r;
      duty_next_s   = duty_r;
    end

    // Predict the conditions of the next cycle so that tick and cycle_done
    // can be registered and still line up with the tick and the wrap.
    tick_next_s       = (presc_r == PRESC_PRE);
    cycle_done_next_s = tick_next_s
                        && (phase_next_s == (period_next_s - PERIOD_W'(1)))
                        && (mode_next_s != MODE_OFF);
  end

  // Decode the LED pattern from the current phase and chase position.
  always_comb begin
    pattern_s = '0;
    on_s      = (phase_r < duty_r);
    case (mode_r)
      MODE_OFF: begin
        pattern_s = '0;
      end
      MODE_BLINK: begin
        pattern_s = {NUM_LEDS{on_s}};
      end
      MODE_CHASE: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          pattern_s[i] = on_s && (pos_r == POS_W'(i));
        end
      end
      MODE_ALT: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          pattern_s[i] = ((i % 2) == 0) ? on_s : !on_s;
        end
      end
      default: begin
        pattern_s = '0;
      end
    endcase
  end

  // Register the counters, the active/pending config and all outputs (synchronous reset).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_r       <= '0;
      phase_r       <= '0;
      period_r      <= PERIOD_W'(1);
      duty_r        <= '0;
      mode_r        <= MODE_OFF;
      pos_r         <= '0;
      ready_r       <= 1'b1;
      pend_mode_r   <= MODE_OFF;
      pend_period_r <= PERIOD_W'(1);
      pend_duty_r   <= '0;
      tick_r        <= 1'b0;
      cycle_done_r  <= 1'b0;
      leds_r        <= LED_POLARITY;
    end else begin
      presc_r      <= presc_next_s;
      phase_r      <= phase_next_s;
      period_r     <= period_next_s;
      duty_r       <= duty_next_s;
      mode_r       <= mode_next_s;
      pos_r        <= pos_next_s;
      tick_r       <= tick_next_s;
      cycle_done_r <= cycle_done_next_s;
      leds_r       <= pattern_s ^ LED_POLARITY;
      if (apply_s) begin
        ready_r <= 1'b1;
      end else if (accept_s) begin
        ready_r       <= 1'b0;
        pend_mode_r   <= mode_t'(cfg.cfg_mode);
        pend_period_r <= (cfg.cfg_period == '0) ? PERIOD_W'(1) : cfg.cfg_period;
        pend_duty_r   <= cfg.cfg_duty;
      end else begin
        ready_r <= ready_r;
      end
    end
  end

  assign cfg.cfg_ready = ready_r;
  assign leds          = leds_r;
  assign tick          = tick_r;
  assign cycle_done    = cycle_done_r;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed test of led_pattern_gen with TICK_DIV=10.
// Each cycle, expected values come from an arithmetic model of the tick,
// phase and position timeline. They are queued on a scoreboard and then
// compared against the DUT outputs at the falling edge.
module tb_led_pattern_gen;
  localparam int NL = 8;
  localparam int PW = 16;

`ifdef LED_INVERT_EN
  localparam logic [7:0] INV = 8'hFF;
`else
  localparam logic [7:0] INV = 8'h00;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NL-1:0] leds;
  logic          tick;
  logic          cycle_done;

  led_pattern_gen_if #(.PERIOD_W(PW)) cfg_bus ();

  led_pattern_gen #(
    .CLK_FREQ(1000),
    .TICK_HZ (100),
    .NUM_LEDS(NL),
    .PERIOD_W(PW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg       (cfg_bus),
    .leds      (leds),
    .tick      (tick),
    .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   n     = 0;

  // Model of the active config and of the pending config
  int m_mode   = 0;
  int m_period = 1;
  int m_duty   = 0;
  int m_s      = 0;
  bit m_pending = 1'b0;
  int pend_s   = 0;
  int pm = 0, pp = 1, pd = 0;

  function automatic string kind_name(input int kind);
    case (kind)
      0: return "leds";
      1: return "tick";
      2: return "cycle_done";
      default: return "cfg_ready";
    endcase
  endfunction

  function automatic logic [15:0] obs_of(input int kind);
    case (kind)
      0: return 16'(leds);
      1: return {15'd0, tick};
      2: return {15'd0, cycle_done};
      default: return {15'd0, cfg_bus.cfg_ready};
    endcase
  endfunction

  // LED value that the state in cycle c produces (seen at c+1)
  function automatic logic [7:0] model_leds(input int c);
    int k, ph, pos;
    bit on;
    logic [7:0] v;
    k   = c / 10 - m_s / 10;
    ph  = k % m_period;
    pos = (k / m_period) % 8;
    on  = (ph < m_duty);
    case (m_mode)
      1: v = on ? 8'hFF : 8'h00;
      2: v = on ? (8'h01 << pos) : 8'h00;
      3: v = on ? 8'h55 : 8'hAA;
      default: v = 8'h00;
    endcase
    return v ^ INV;
  endfunction

  function automatic bit model_cd(input int c);
    int k;
    k = c / 10 - m_s / 10;
    return (c % 10 == 9) && ((k % m_period) == m_period - 1) && (m_mode != 0);
  endfunction

  // First wrap cycle strictly after cycle a under the active config
  function automatic int next_wrap(input int a);
    for (int t = a + 1; t < a + 1000; t++) begin
      if ((t % 10 == 9) && (((t / 10 - m_s / 10) % m_period) == m_period - 1)) return t;
    end
    return -1;
  endfunction

  task automatic push(input int kind, input logic [15:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [15:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs_of(e.kind);
      total++;
      assert (o === e.val) else begin
        bad++;
        $error("FAIL %s cyc=%0d obs=%0h exp=%0h", kind_name(e.kind), n, o, e.val);
      end
    end
  endtask

  task automatic cyc();
    logic [7:0] nl;
    nl = model_leds(n);
    @(negedge clk);
    n++;
    if (m_pending && n == pend_s) begin
      m_mode    = pm;
      m_period  = pp;
      m_duty    = pd;
      m_s       = n;
      m_pending = 1'b0;
    end
    push(0, 16'(nl));
    push(1, {15'd0, (n % 10 == 9)});
    push(2, {15'd0, model_cd(n)});
    push(3, {15'd0, !m_pending});
    drain();
  endtask

  task automatic run_to(input int target);
    while (n < target) cyc();
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    m_pending = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      push(0, 16'(INV));
      push(1, 16'd0);
      push(2, 16'd0);
      push(3, 16'd1);
      drain();
    end
    rst_n    = 1'b1;
    n        = 0;
    m_mode   = 0;
    m_period = 1;
    m_duty   = 0;
    m_s      = 0;
  endtask

  task automatic offer(input logic [1:0] md, input int per, input int dty);
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_mode   = md;
    cfg_bus.cfg_period = 16'(per);
    cfg_bus.cfg_duty   = 16'(dty);
    pm = int'(md);
    pp = (per == 0) ? 1 : per;
    pd = dty;
    if (m_mode == 0) pend_s = n + 2;
    else pend_s = next_wrap(n) + 1;
    m_pending = 1'b1;
    cyc();
    cfg_bus.cfg_valid = 1'b0;
  endtask

  initial begin
    int t;
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus.cfg_mode   = 2'd0;
    cfg_bus.cfg_period = 16'd0;
    cfg_bus.cfg_duty   = 16'd0;

    // Reset, then idle OFF: tick every 10 cycles, first at cycle 9
    do_reset(3);
    run_to(30);

    // BLINK period 4 duty 2 from OFF: 20 cycles on, 20 cycles off
    offer(2'd1, 4, 2);
    run_to(155);

    // ALT offered mid-period. Junk offers are ignored while not ready.
    offer(2'd3, 2, 1);
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_mode   = 2'd2;
    cfg_bus.cfg_period = 16'd7;
    cfg_bus.cfg_duty   = 16'd3;
    repeat (3) cyc();
    cfg_bus.cfg_valid  = 1'b0;
    run_to(260);

    // CHASE period 1 duty 1: walking one, advancing every tick
    offer(2'd2, 1, 1);
    run_to(360);

    // period 0 is stored as 1; duty 5 >= period, so always on
    offer(2'd1, 0, 5);
    run_to(410);

    // duty 0 means never on
    offer(2'd1, 4, 0);
    run_to(470);

    // Accept in the same cycle as a wrap applies one period later
    t = next_wrap(n - 1);
    run_to(t);
    offer(2'd3, 2, 1);
    run_to(600);

    // Reset during CHASE with a config pending discards the pending config
    offer(2'd2, 1, 1);
    run_to(630);
    offer(2'd3, 3, 1);
    cyc();
    do_reset(2);
    run_to(80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
